// File: rtl/cyclic_decoder_meggitt.sv
// Serial Meggitt decoder for the (15,11) cyclic code, g(x)=x^4+x+1.
// A receive stage builds the syndrome while the drain stage emits corrected data of the previous word.
module cyclic_decoder_meggitt #(
  parameter int N = 15,
  parameter int K = 11,
  parameter logic [3:0] MEGGITT = 4'b1001
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_sof,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_sof,
  output logic out_eof,
  output logic out_err,
  output logic sof_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_IN = CW'(N - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, RECV, FULL} rx_state_t;

  rx_state_t rx_state;
  logic [CW-1:0] rx_cnt;
  logic [N-1:0] rx_buf;
  logic [3:0] rx_syn;

  logic d_busy;
  logic [N-1:0] d_buf;
  logic [3:0] d_syn;
  logic [CW-1:0] d_cnt;
  logic d_err;

  logic accept;
  logic fb;
  logic [3:0] syn_shift;
  logic [N-1:0] buf_shift;
  logic last_bit;
  logic d_take;
  logic d_last;
  logic drain_free;
  logic load_now;
  logic load;
  logic [N-1:0] load_buf;
  logic [3:0] load_syn;
  logic d_corr;
  logic [3:0] syn_rot;

  assign in_ready  = (rx_state != FULL);
  assign accept    = in_valid & in_ready;
  assign fb        = rx_syn[3];
  assign syn_shift = {rx_syn[2], rx_syn[1], rx_syn[0] ^ fb, in_bit ^ fb};
  assign buf_shift = {rx_buf[N-2:0], in_bit};
  assign last_bit  = accept & ~in_sof & (rx_state == RECV) & (rx_cnt == LAST_IN);

  // The drain stage counts as free on the edge that retires its last bit.
  assign d_take     = d_busy & out_ready;
  assign d_last     = d_take & (d_cnt == LAST_OUT);
  assign drain_free = ~d_busy | d_last;
  assign load_now   = last_bit & drain_free;
  assign load       = load_now | ((rx_state == FULL) & drain_free);
  assign load_buf   = load_now ? buf_shift : rx_buf;
  assign load_syn   = load_now ? syn_shift : rx_syn;

  assign d_corr  = (d_syn == MEGGITT);
  assign syn_rot = {d_syn[2:0], 1'b0} ^ (d_syn[3] ? 4'b0011 : 4'b0000);

  assign out_valid = d_busy;
  assign out_bit   = d_busy & (d_buf[N-1] ^ d_corr);
  assign out_sof   = d_busy & (d_cnt == '0);
  assign out_eof   = d_busy & (d_cnt == LAST_OUT);
  assign out_err   = d_busy & d_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_buf   <= '0;
      rx_syn   <= '0;
      sof_err  <= 1'b0;
    end else begin
      sof_err <= accept & in_sof & (rx_state == RECV);
      case (rx_state)
        IDLE, RECV: begin
          if (accept) begin
            if (in_sof) begin
              rx_state <= RECV;
              rx_cnt   <= CW'(1);
              rx_buf   <= {{(N-1){1'b0}}, in_bit};
              rx_syn   <= {3'b000, in_bit};
            end else if (rx_state == RECV) begin
              rx_buf <= buf_shift;
              rx_syn <= syn_shift;
              if (rx_cnt == LAST_IN) begin
                rx_state <= drain_free ? IDLE : FULL;
                rx_cnt   <= '0;
              end else begin
                rx_cnt <= rx_cnt + 1'b1;
              end
            end
          end
        end
        FULL: begin
          if (drain_free) rx_state <= IDLE;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_busy <= 1'b0;
      d_buf  <= '0;
      d_syn  <= '0;
      d_cnt  <= '0;
      d_err  <= 1'b0;
    end else if (load) begin
      d_busy <= 1'b1;
      d_buf  <= load_buf;
      d_syn  <= load_syn;
      d_cnt  <= '0;
      d_err  <= |load_syn;
    end else if (d_take) begin
      d_buf <= {d_buf[N-2:0], 1'b0};
      // Once the error bit has been fixed the syndrome is spent.
      d_syn <= d_corr ? 4'b0000 : syn_rot;
      d_cnt <= d_cnt + 1'b1;
      if (d_last) d_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cyclic_decoder_meggitt.sv
// Bench for cyclic_decoder_meggitt: polynomial-division model feeding an expected-word queue,
// plus directed scenarios with literal expectations.
module tb_cyclic_decoder_meggitt;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic in_bit = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_bit, out_sof, out_eof, out_err, sof_err;

  cyclic_decoder_meggitt dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_sof(out_sof), .out_eof(out_eof), .out_err(out_err), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] data;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  int idx = 0;
  int words_done = 0;
  int sof_pulses = 0;
  int checks = 0;
  int errors = 0;
  int or_mode = 0;
  bit saw_stall = 1'b0;
  logic [10:0] cur_word = '0;
  logic [10:0] last_word = '0;
  logic last_err = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Remainder of r(x) by g(x) via long division.
  function automatic logic [3:0] mod_g(logic [14:0] r);
    logic [14:0] t;
    t = r;
    for (int i = 14; i >= 4; i--)
      if (t[i]) t = t ^ (15'(5'b10011) << (i - 4));
    return t[3:0];
  endfunction

  function automatic logic [14:0] encode(logic [10:0] d);
    return {d, mod_g({d, 4'b0000})};
  endfunction

  function automatic exp_t decode(logic [14:0] r);
    exp_t e;
    logic [3:0] s;
    logic [14:0] c;
    c = r;
    s = mod_g(r);
    e.err = (s != 4'b0000);
    for (int i = 0; i < 15; i++)
      if (s != 4'b0000 && mod_g(15'(1) << i) == s) c[i] = ~c[i];
    e.data = c[14:4];
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  // Per-cycle output check against the expected-word queue.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      idx = 0;
    end else begin
      if (!in_ready) saw_stall = 1'b1;
      if (sof_err) sof_pulses++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          check("out_bit", out_bit, exp_q[0].data[10-idx]);
          check("out_sof", out_sof, idx == 0);
          check("out_eof", out_eof, idx == 10);
          check("out_err", out_err, exp_q[0].err);
          if (out_ready) begin
            cur_word[10-idx] = out_bit;
            idx++;
            if (idx == 11) begin
              last_word = cur_word;
              last_err = out_err;
              words_done++;
              void'(exp_q.pop_front());
              idx = 0;
            end
          end
        end
      end
    end
  end

  task automatic send(logic [14:0] cw, int nbits, bit push);
    int g;
    for (int i = 14; i > 14 - nbits; i--) begin
      in_valid = 1'b1;
      in_sof = (i == 14);
      in_bit = cw[i];
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 300) begin
        g++;
        @(negedge clk);
      end
      if (g >= 300) check("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    if (push) exp_q.push_back(decode(cw));
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (g < 600 && (out_valid || exp_q.size() != 0)) begin
      g++;
      @(negedge clk);
    end
    if (g >= 600) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(string name, logic [10:0] data, logic err);
    check({name, "_data"}, last_word, data);
    check({name, "_err"}, last_err, err);
  endtask

  initial begin
    logic [14:0] cw;
    logic [10:0] d;
    int pos;
    int base;
    int g;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eof", out_eof, 0);
    check("rst_out_err", out_err, 0);
    check("rst_sof_err", sof_err, 0);
    reset = 1'b0;

    check("model_x14", mod_g(15'h4000), 4'b1001);
    check("model_encode", encode(11'b10000000000), 15'b100000000001001);

    // Clean word with latency check.
    send(15'b100000000001001, 15, 1);
    check("lat_out_valid", out_valid, 1);
    check("lat_out_sof", out_sof, 1);
    wait_idle();
    check_word("clean", 11'b10000000000, 1'b0);

    send(15'b000000000001001, 15, 1);
    wait_idle();
    check_word("flip_c14", 11'b10000000000, 1'b1);

    send(15'b100000000011001, 15, 1);
    wait_idle();
    check_word("flip_c4", 11'b10000000000, 1'b1);

    send(15'b100000000001000, 15, 1);
    wait_idle();
    check_word("flip_c0", 11'b10000000000, 1'b1);

    // Back-to-back words with a throttled consumer.
    saw_stall = 1'b0;
    or_mode = 1;
    send(encode(11'b10110011100), 15, 1);
    cw = encode(11'b01001100011);
    cw[9] = ~cw[9];
    send(cw, 15, 1);
    wait_idle();
    check_word("b2b_second", 11'b01001100011, 1'b1);
    check("b2b_stall_seen", saw_stall, 1);
    or_mode = 0;
    check("sof_err_none_yet", sof_pulses, 0);

    // Restart mid-frame.
    send(encode(11'b11111111111), 7, 0);
    send(encode(11'b00110101010), 15, 1);
    wait_idle();
    check_word("restart", 11'b00110101010, 1'b0);
    check("sof_err_pulses", sof_pulses, 1);

    for (int n = 0; n < 20; n++) begin
      d = 11'($urandom);
      cw = encode(d);
      pos = $urandom_range(0, 15);
      if (pos < 15) cw[pos] = ~cw[pos];
      or_mode = n % 2;
      send(cw, 15, 1);
    end
    wait_idle();
    or_mode = 0;
    check("words_done", words_done, 27);

    // Reset while draining with another word waiting.
    or_mode = 2;
    send(encode(11'b11001010011), 15, 1);
    send(encode(11'b01110001101), 15, 1);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    or_mode = 0;
    base = words_done;
    g = 0;
    while (idx < 5 && g < 100) begin
      g++;
      @(negedge clk);
    end
    if (g >= 100) check("reach_cnt5_timeout", 0, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst2_in_ready", in_ready, 1);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_sof", out_sof, 0);
    check("rst2_out_err", out_err, 0);
    repeat (40) @(posedge clk);
    #1;
    check("rst2_no_words", words_done, base);
    check("rst2_idle_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
